// File: rtl/lane_pkg.sv
// Shared defaults and state encoding for the lane sequencer.
// Included first so the sub-module and top can import it.
package lane_pkg;

  localparam int DEF_DATA_W    = 512;
  localparam int DEF_LANE_W    = 128;
  localparam int DEF_NUM_LANES = DEF_DATA_W / DEF_LANE_W;
  localparam int DEF_CNT_W     = 16;
  localparam int LANE_IDX_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/lane_pick.sv
// Combinational lane selection: the lowest enabled lane, the next enabled lane
// above cur_i, and whether cur_i is the highest enabled lane.
module lane_pick
  import lane_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES
) (
  input  logic [NUM_LANES-1:0]  mask_i,
  input  logic [LANE_IDX_W-1:0] cur_i,
  output logic [LANE_IDX_W-1:0] next_o,
  output logic [LANE_IDX_W-1:0] first_o,
  output logic                  last_o
);

  logic found_next;

  // Descending scans so the lowest qualifying index is the one left standing.
  always_comb begin
    next_o     = '0;
    first_o    = '0;
    found_next = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        first_o = LANE_IDX_W'(i);
      end
      if (mask_i[i] && (i > int'(cur_i))) begin
        next_o     = LANE_IDX_W'(i);
        found_next = 1'b1;
      end
    end
    last_o = !found_next;
  end

endmodule

// File: rtl/lane_sequencer.sv
// Splits a wide input word into lane-sized beats, emitting only the lanes
// selected by a per-word mask, with a same-cycle reload on the final beat.
module lane_sequencer
  import lane_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LANE_W    = DEF_LANE_W,
  parameter int CNT_W     = DEF_CNT_W,
  localparam int NUM_LANES = DATA_W / LANE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [NUM_LANES-1:0] lane_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANE_W-1:0]    out_data,
  output logic [1:0]           out_lane,
  output logic                 out_last,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload while valid && !ready, the consumer never stalls
  // by withdrawing valid.
  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [NUM_LANES-1:0]   mask_q, mask_d;
  logic                   out_valid_q, out_valid_d;
  logic [LANE_W-1:0]      out_data_q, out_data_d;
  logic [1:0]             out_lane_q, out_lane_d;
  logic                   out_last_q, out_last_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   fire_in;
  logic                   fire_out;
  logic [NUM_LANES-1:0]   in_mask_eff;
  logic [NUM_LANES-1:0]   mask_sel;
  logic [DATA_W-1:0]      data_sel;
  logic [1:0]             pick_first;
  logic [1:0]             pick_next;
  logic [1:0]             new_idx;
  logic [LANE_W-1:0]      new_lane_data;
  logic                   new_last;
  logic                   unused_pick;
  logic                   unused_cur_last;
  logic [1:0]             unused_new_next;
  logic [1:0]             unused_new_first;

  // An empty mask means "send every lane".
  assign in_mask_eff = (lane_mask == '0) ? '1 : lane_mask;

  assign fire_out = out_valid_q && out_ready;
  assign in_ready = (state_q == IDLE) || (fire_out && out_last_q);
  assign fire_in  = in_valid && in_ready;

  // A fresh word selects from its own mask/data; otherwise we walk the held word.
  assign mask_sel = fire_in ? in_mask_eff : mask_q;
  assign data_sel = fire_in ? in_data : data_q;
  assign new_idx  = fire_in ? pick_first : pick_next;
  assign new_lane_data = data_sel[int'(new_idx)*LANE_W +: LANE_W];

  lane_pick #(
    .NUM_LANES (NUM_LANES)
  ) u_pick_cur (
    .mask_i  (mask_sel),
    .cur_i   (out_lane_q),
    .next_o  (pick_next),
    .first_o (pick_first),
    .last_o  (unused_cur_last)
  );

  lane_pick #(
    .NUM_LANES (NUM_LANES)
  ) u_pick_new (
    .mask_i  (mask_sel),
    .cur_i   (new_idx),
    .next_o  (unused_new_next),
    .first_o (unused_new_first),
    .last_o  (new_last)
  );

  assign unused_pick = ^{unused_cur_last, unused_new_next, unused_new_first};

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    out_last_d  = out_last_q;
    count_d     = count_q;

    if (fire_in) begin
      state_d     = SEND;
      data_d      = in_data;
      mask_d      = in_mask_eff;
      out_valid_d = 1'b1;
      out_lane_d  = new_idx;
      out_data_d  = new_lane_data;
      out_last_d  = new_last;
    end else if (fire_out && !out_last_q) begin
      out_lane_d  = new_idx;
      out_data_d  = new_lane_data;
      out_last_d  = new_last;
    end else if (fire_out) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_lane_d  = '0;
      out_last_d  = 1'b0;
    end

    if (fire_out && out_last_q) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      out_last_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      out_last_q  <= out_last_d;
      count_q     <= count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_lane   = out_lane_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q == SEND);
  assign word_count = count_q;

endmodule

// File: tb/tb_lane_sequencer.sv
// Bench for lane_sequencer: a beat-queue reference model checked every cycle,
// a table of directed words, stall/stream/reset sequences and random traffic.
module tb_lane_sequencer;

  localparam int DATA_W = 512;
  localparam int LANE_W = 128;
  localparam int CNT_W  = 8;   // narrow so the counter wrap is reached quickly

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [3:0]        lane_mask;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_data;
  logic [1:0]        out_lane;
  logic              out_last;
  logic              busy;
  logic [CNT_W-1:0]  word_count;

  lane_sequencer #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .lane_mask  (lane_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_last   (out_last),
    .busy       (busy),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        lane;
    logic [LANE_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    logic [3:0]        mask;
    logic [DATA_W-1:0] data;
    int                n;
    logic [7:0]        lanes;  // expected lane of beat j at [2j+:2]
  } vec_t;

  beat_t exp_q[$];   // beats the model still owes
  beat_t obs_q[$];   // beats the DUT handed over
  int    exp_cnt;
  int    n_vec;
  int    n_err;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [3:0] m,
                       input logic r);
    logic       exp_valid;
    logic       exp_ready;
    logic [3:0] mm;
    int         hi;
    beat_t      b;
    in_valid  = v;
    in_data   = d;
    lane_mask = m;
    out_ready = r;
    #1;
    exp_valid = (exp_q.size() > 0);
    exp_ready = (exp_q.size() == 0) || (r && exp_q.size() == 1);
    check("in_ready", 128'(in_ready), 128'(exp_ready));
    check("out_valid", 128'(out_valid), 128'(exp_valid));
    check("busy", 128'(busy), 128'(exp_valid));
    check("word_count", 128'(word_count), 128'(exp_cnt % (1 << CNT_W)));
    if (exp_valid) begin
      check("out_lane", 128'(out_lane), 128'(exp_q[0].lane));
      check("out_data", 128'(out_data), 128'(exp_q[0].data));
      check("out_last", 128'(out_last), 128'(exp_q[0].last));
    end else begin
      check("idle_outs", 128'({out_data, out_lane, out_last}), 128'(0));
    end
    if (out_valid && r) begin
      b.lane = out_lane;
      b.data = out_data;
      b.last = out_last;
      obs_q.push_back(b);
    end
    if (exp_valid && r) begin
      if (exp_q[0].last) exp_cnt++;
      void'(exp_q.pop_front());
    end
    if (v && exp_ready) begin
      mm = (m == 4'b0000) ? 4'b1111 : m;
      hi = 0;
      for (int i = 0; i < 4; i++) if (mm[i]) hi = i;
      for (int i = 0; i < 4; i++) begin
        if (mm[i]) begin
          b.lane = 2'(i);
          b.data = d[i*LANE_W +: LANE_W];
          b.last = (i == hi);
          exp_q.push_back(b);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() > 0; k++) cycle(1'b0, '0, 4'h0, 1'b1);
    check("drain_budget", 128'(exp_q.size()), 128'(0));
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  vec_t              tbl[6];
  logic [DATA_W-1:0] d_stall;
  logic [1:0]        el;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_cnt = 0;
    tbl[0] = '{4'hF, {4{128'h1234567890abcdef1234567890abcdef}}, 4, 8'hE4};
    tbl[1] = '{4'b1010, {128'hD, 128'hC, 128'hB, 128'hA}, 2, 8'h0D};
    tbl[2] = '{4'b0000, {128'h44, 128'h33, 128'h22, 128'h11}, 4, 8'hE4};
    tbl[3] = '{4'b0100, {128'hF3, 128'hF2, 128'hF1, 128'hF0}, 1, 8'h02};
    tbl[4] = '{4'b1001, {128'hA3, 128'hA2, 128'hA1, 128'hA0}, 2, 8'h0C};
    tbl[5] = '{4'b0111, {128'h73, 128'h72, 128'h71, 128'h70}, 3, 8'h24};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    lane_mask = 4'h0;
    out_ready = 1'b0;
    #1;
    check("rst_outs", 128'({out_valid, out_data, out_lane, out_last, busy}), 128'(0));
    check("rst_count", 128'(word_count), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));

    foreach (tbl[t]) begin
      obs_q.delete();
      cycle(1'b1, tbl[t].data, tbl[t].mask, 1'b1);
      drain(10);
      check("tbl_nbeats", 128'(obs_q.size()), 128'(tbl[t].n));
      for (int j = 0; j < obs_q.size() && j < tbl[t].n; j++) begin
        el = tbl[t].lanes[2*j +: 2];
        check("tbl_lane", 128'(obs_q[j].lane), 128'(el));
        check("tbl_data", 128'(obs_q[j].data), tbl[t].data[int'(el)*LANE_W +: LANE_W]);
        check("tbl_last", 128'(obs_q[j].last), 128'(j == tbl[t].n - 1));
      end
    end

    // Hold lane 1 for three cycles of back-pressure.
    obs_q.delete();
    d_stall = rand_word();
    cycle(1'b1, d_stall, 4'hF, 1'b1);
    cycle(1'b0, '0, 4'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, rand_word(), 4'hF, 1'b0);
      check("stall_lane", 128'(out_lane), 128'(1));
      check("stall_data", 128'(out_data), d_stall[LANE_W +: LANE_W]);
    end
    drain(10);
    check("stall_nbeats", 128'(obs_q.size()), 128'(4));
    for (int j = 0; j < obs_q.size() && j < 4; j++) check("stall_order", 128'(obs_q[j].lane), 128'(j));

    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom_range(0, 2) != 0), rand_word(), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
    end
    drain(10);

    // Back-to-back single-lane words past the counter wrap.
    for (int k = 0; k < 300; k++) begin
      cycle(1'b1, rand_word(), 4'b0001, 1'b1);
      check("stream_beat", 128'({out_valid, out_last}), 128'(2'b11));
    end
    drain(10);

    // Reset in the middle of a word after lanes 0 and 1 were taken.
    obs_q.delete();
    cycle(1'b1, rand_word(), 4'hF, 1'b1);
    cycle(1'b0, '0, 4'h0, 1'b1);
    cycle(1'b0, '0, 4'h0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", 128'({out_valid, out_data, out_lane, out_last, busy}), 128'(0));
    check("mid_rst_count", 128'(word_count), 128'(0));
    exp_q.delete();
    exp_cnt = 0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) cycle(1'b0, '0, 4'h0, 1'b1);
    check("mid_rst_tail", 128'(obs_q.size()), 128'(2));
    cycle(1'b1, rand_word(), 4'b0110, 1'b1);
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lane_sequencer.md
LANE_SEQUENCER -- requirements
Module: lane_sequencer

Interface
REQ-001 Parameter DATA_W, default 512, SHALL set the input word width.
REQ-002 Parameter LANE_W, default 128, SHALL set the lane width; NUM_LANES = DATA_W/LANE_W = 4.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of word_count.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  DATA_W  word; lane i = bits [LANE_W*i+LANE_W-1 : LANE_W*i].
REQ-009 lane_mask  input  NUM_LANES  lanes to emit, sampled with in_data on accept.
REQ-010 out_valid  output  1  lane beat valid.
REQ-011 out_ready  input  1  downstream accepts beat.
REQ-012 out_data  output  LANE_W  current lane payload.
REQ-013 out_lane  output  2  index of current lane.
REQ-014 out_last  output  1  current beat is the final enabled lane of the word.
REQ-015 busy  output  1  a word is held and not yet fully emitted.
REQ-016 word_count  output  CNT_W  count of completed words.

Function
REQ-017 Two states SHALL exist: IDLE (no word held) and SEND (word held, beats pending).
REQ-018 Input handshake SHALL occur when in_valid && in_ready; in_data and lane_mask captured into registers at that edge.
REQ-019 in_ready SHALL be 1 in IDLE, and in SEND only when out_valid && out_ready && out_last (same-cycle reload); otherwise 0.
REQ-020 A captured lane_mask of 4'b0000 SHALL be treated as 4'b1111.
REQ-021 Beats SHALL be emitted in ascending lane index, enabled lanes only; disabled lanes consume no cycles.
REQ-022 First beat SHALL have out_valid=1 in the cycle after input handshake (1-cycle latency); all outputs registered.
REQ-023 Output handshake SHALL occur when out_valid && out_ready; the next enabled lane SHALL be presented the following cycle.
REQ-024 While out_valid && !out_ready, out_data, out_lane, out_last SHALL hold stable.
REQ-025 out_last SHALL be 1 exactly on the highest enabled lane beat.
REQ-026 On last-beat handshake without new input handshake: state -> IDLE, out_valid=0 next cycle.
REQ-027 On last-beat handshake with simultaneous input handshake: stay SEND, first lane of new word presented next cycle, no bubble.
REQ-028 word_count SHALL increment by 1 on each last-beat handshake, wrapping 2^CNT_W-1 -> 0.
REQ-029 busy SHALL equal (state == SEND).
REQ-030 out_data/out_lane/out_last SHALL be don't-care when out_valid=0 but driven to 0 in IDLE.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, out_valid=0, out_data=0, out_lane=0, out_last=0, word_count=0, busy=0, held word/mask cleared.
REQ-032 Reset mid-word SHALL discard remaining beats; no beat emitted after rst_n deasserts until a new input handshake.
REQ-033 in_ready SHALL be 1 from the first clock edge after rst_n deasserts.

Structure
REQ-034 Package lane_pkg SHALL hold DATA_W, LANE_W, NUM_LANES defaults and the state enum (IDLE, SEND).
REQ-035 Sub-module lane_pick SHALL be combinational: given mask and current index, return next enabled index above current, first enabled index, and a last flag.

Verification
REQ-036 Reset, then in_data={4{128'h1234567890abcdef1234567890abcdef}}, mask 4'hF, out_ready=1 -> 4 beats lanes 0,1,2,3 each 128'h1234567890abcdef1234567890abcdef, out_last on lane 3, word_count=1.
REQ-037 in_data lanes 3..0 = 128'hD,128'hC,128'hB,128'hA, mask 4'b1010 -> beats (lane1, 128'hB), (lane3, 128'hD, out_last); 2 cycles only.
REQ-038 mask 4'b0000 -> behaves as 4'hF, 4 beats emitted.
REQ-039 out_ready low 3 cycles on lane 1 -> out_data/out_lane stable 3 cycles, in_ready=0, no lane skipped.
REQ-040 Continuous in_valid, mask 4'b0001, out_ready=1 -> one beat per cycle, out_last every beat, in_ready=1 every cycle, word_count +1 per cycle; preset path wraps 16'hFFFF -> 0.
REQ-041 rst_n pulsed low after lane 1 handshake -> outputs 0 immediately, lanes 2-3 never appear, word_count=0.
